// File: rtl/audio_player_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : audio_player_mc
//  Description : Multi-channel music player. Beat clock, play/pause/stop/loop
//                sequencing, N tone PWM generators and a PMOD amplifier mixer.
//                ibeat addresses an external score ROM that returns per-channel
//                tone periods.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_player_mc #(
    parameter int CHANNELS = 2,
    parameter int BEAT_W   = 8,
    parameter int PER_W    = 20,
    parameter int DUTY_W   = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      stop,
    input  logic                      loop_en,
    input  logic [BEAT_W-1:0]         song_len,
    input  logic [PER_W-1:0]          beat_div,
    input  logic [CHANNELS*PER_W-1:0] tone_period,
    input  logic [DUTY_W-1:0]         volume,
    input  logic [CHANNELS-1:0]       mute,
    input  logic                      gain_hi,
    output logic [BEAT_W-1:0]         ibeat,
    output logic                      playing,
    output logic                      done,
    output logic [CHANNELS-1:0]       pwm_ch,
    output logic                      pmod_1,
    output logic                      pmod_2,
    output logic                      pmod_4
);

    localparam logic [PER_W-1:0] C_ONE = {{(PER_W-1){1'b0}}, 1'b1};
    localparam logic [PER_W-1:0] C_TWO = {{(PER_W-2){1'b0}}, 2'b10};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   ibeat_q, ibeat_d;
    logic [PER_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                done_q, done_d;
    logic                reload_q, reload_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                pmod1_q;
    logic [PER_W-1:0]    div_eff;
    logic                beat_wrap;
    logic                start_play;

    // A zero divider would never wrap, so it behaves as one cycle per beat.
    assign div_eff   = (beat_div == '0) ? C_ONE : beat_div;
    // >= keeps the counter bounded if beat_div shrinks mid-beat.
    assign beat_wrap = (beat_cnt_q >= (div_eff - C_ONE));

    // Sequencer next state: stop beats start beats pause; beat ticks in PLAY.
    always_comb begin
        state_d    = state_q;
        ibeat_d    = ibeat_q;
        beat_cnt_d = beat_cnt_q;
        done_d     = 1'b0;
        start_play = 1'b0;
        if (stop) begin
            state_d    = S_IDLE;
            ibeat_d    = '0;
            beat_cnt_d = '0;
        end else if (start && (state_q == S_IDLE)) begin
            state_d    = S_PLAY;
            ibeat_d    = '0;
            beat_cnt_d = '0;
            start_play = 1'b1;
        end else if (start && (state_q == S_PAUSE)) begin
            state_d = S_PLAY;
        end else if (pause && (state_q == S_PLAY)) begin
            state_d = S_PAUSE;
        end else if (state_q == S_PLAY) begin
            if (beat_wrap) begin
                beat_cnt_d = '0;
                // A song_len below the current beat counts as the song end.
                if (ibeat_q < song_len) begin
                    ibeat_d = ibeat_q + 1'b1;
                end else if (loop_en) begin
                    ibeat_d = '0;
                end else begin
                    state_d = S_IDLE;
                    ibeat_d = '0;
                    done_d  = 1'b1;
                end
            end else begin
                beat_cnt_d = beat_cnt_q + C_ONE;
            end
        end
        // Tone periods are re-sampled one clock after ibeat moves or play begins.
        reload_d = start_play || (ibeat_d != ibeat_q);
    end

    // Sequencer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ibeat_q    <= '0;
            beat_cnt_q <= '0;
            done_q     <= 1'b0;
            reload_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ibeat_q    <= ibeat_d;
            beat_cnt_q <= beat_cnt_d;
            done_q     <= done_d;
            reload_q   <= reload_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [PER_W-1:0]        period_q;
        logic [PER_W-1:0]        tcnt_q, tcnt_d;
        logic [PER_W+DUTY_W-1:0] product;
        logic [PER_W-1:0]        high_time;

        // Full-width product so that the shift keeps every significant bit.
        assign product   = {{DUTY_W{1'b0}}, period_q} * {{PER_W{1'b0}}, volume};
        assign high_time = product[PER_W+DUTY_W-1:DUTY_W];
        // Periods below two are rests and hold the counter at zero.
        assign tcnt_d    = reload_q                           ? '0 :
                           (period_q < C_TWO)                 ? '0 :
                           (tcnt_q >= (period_q - C_ONE))     ? '0 :
                                                                tcnt_q + C_ONE;
        assign pwm_d[c]  = (state_q == S_PLAY) && (period_q >= C_TWO) &&
                           (tcnt_q < high_time);

        // Period register and free-running tone counter for this voice.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                period_q <= '0;
                tcnt_q   <= '0;
            end else begin
                if (reload_q) begin
                    period_q <= tone_period[c*PER_W +: PER_W];
                end
                tcnt_q <= tcnt_d;
            end
        end
    end

    // Registered PWM outputs and the muted mix one stage behind them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_q   <= '0;
            pmod1_q <= 1'b0;
        end else begin
            pwm_q   <= pwm_d;
            pmod1_q <= |(pwm_q & ~mute);
        end
    end

    assign ibeat   = ibeat_q;
    assign playing = (state_q == S_PLAY);
    assign done    = done_q;
    assign pwm_ch  = pwm_q;
    assign pmod_1  = pmod1_q;
    assign pmod_2  = gain_hi;
    assign pmod_4  = (state_q != S_IDLE);

endmodule
`default_nettype wire
